// File: rtl/core_frame_loader_pkg.sv
// Shared definitions for the per-core frame loader: default frame geometry,
// frame-bus slicing helpers and the loader state encoding.
package core_frame_loader_pkg;

  localparam int DEF_INSN_WIDTH  = 16;
  localparam int DEF_FRAME_INSNS = 16;
  localparam int DEF_R0_WIDTH    = 8;

  // Bit offset of instruction k inside the broadcast frame bus.
  function automatic int insnLsb(input int k, input int insnWidth);
    return k * insnWidth;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } loaderState_t;

endpackage

// File: rtl/core_frame_loader_frame_serializer.sv
// Latches one broadcast frame and streams it into the instruction memory,
// one word per cycle, starting at address 0 on the cycle after the load.
module core_frame_loader_frame_serializer
  import core_frame_loader_pkg::*;
#(
  parameter int INSN_WIDTH  = DEF_INSN_WIDTH,
  parameter int FRAME_INSNS = DEF_FRAME_INSNS,
  parameter int ADDR_W      = $clog2(FRAME_INSNS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_load,
  input  logic [FRAME_INSNS*INSN_WIDTH-1:0] i_frame,
  output logic                              o_imemWe,
  output logic [ADDR_W-1:0]                 o_imemAddr,
  output logic [INSN_WIDTH-1:0]             o_imemWdata,
  output logic                              o_lastWrite
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(FRAME_INSNS - 1);

  logic [INSN_WIDTH-1:0] r_buf [FRAME_INSNS];
  logic [ADDR_W:0]       r_wcnt;
  logic [ADDR_W-1:0]     w_nextAddr;

  assign w_nextAddr  = r_wcnt[ADDR_W-1:0] + ADDR_W'(1);
  assign o_lastWrite = o_imemWe && (r_wcnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int k = 0; k < FRAME_INSNS; k++) begin
        r_buf[k] <= i_frame[insnLsb(k, INSN_WIDTH) +: INSN_WIDTH];
      end
    end
  end

  // Word 0 comes straight off the bus on the load edge so the first write
  // lands on the very next cycle; later words come only from the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wcnt      <= '0;
      o_imemWe    <= 1'b0;
      o_imemAddr  <= '0;
      o_imemWdata <= '0;
    end else if (i_load) begin
      r_wcnt      <= '0;
      o_imemWe    <= 1'b1;
      o_imemAddr  <= '0;
      o_imemWdata <= i_frame[INSN_WIDTH-1:0];
    end else if (o_imemWe) begin
      if (r_wcnt == LAST_IDX) begin
        o_imemWe <= 1'b0;
      end else begin
        r_wcnt      <= r_wcnt + (ADDR_W+1)'(1);
        o_imemAddr  <= w_nextAddr;
        o_imemWdata <= r_buf[w_nextAddr];
      end
    end
  end

endmodule

// File: rtl/core_frame_loader.sv
// Per-core frame loader: accepts a scheduler frame, writes it into the core's
// instruction memory, optionally seeds R0, launches the core, waits for halt.
module core_frame_loader
  import core_frame_loader_pkg::*;
#(
  parameter int INSN_WIDTH  = DEF_INSN_WIDTH,
  parameter int FRAME_INSNS = DEF_FRAME_INSNS,
  parameter int R0_WIDTH    = DEF_R0_WIDTH,
  localparam int ADDR_W     = $clog2(FRAME_INSNS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [FRAME_INSNS*INSN_WIDTH-1:0] insn_data,
  input  logic                              init_r0_vect,
  input  logic [R0_WIDTH-1:0]               init_r0,
  input  logic                              core_halt,
  output logic                              ready,
  output logic                              imem_we,
  output logic [ADDR_W-1:0]                 imem_addr,
  output logic [INSN_WIDTH-1:0]             imem_wdata,
  output logic                              r0_we,
  output logic [R0_WIDTH-1:0]               r0_wdata,
  output logic                              core_run
);

  loaderState_t r_state;
  logic         r_firstFrame;
  logic         w_accept;
  logic         w_lastWrite;

  assign w_accept = (r_state == ST_IDLE) && start;

  core_frame_loader_frame_serializer #(
    .INSN_WIDTH  (INSN_WIDTH),
    .FRAME_INSNS (FRAME_INSNS),
    .ADDR_W      (ADDR_W)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_frame     (insn_data),
    .o_imemWe    (imem_we),
    .o_imemAddr  (imem_addr),
    .o_imemWdata (imem_wdata),
    .o_lastWrite (w_lastWrite)
  );

  // start drops only between tasks, so any low cycle re-arms the R0 seed
  // for the next accepted frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      ready        <= 1'b1;
      r0_we        <= 1'b0;
      r0_wdata     <= '0;
      core_run     <= 1'b0;
      r_firstFrame <= 1'b1;
    end else begin
      r0_we    <= 1'b0;
      core_run <= 1'b0;
      if (!start) begin
        r_firstFrame <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            ready        <= 1'b0;
            r_state      <= ST_LOAD;
            r_firstFrame <= 1'b0;
            if (r_firstFrame && init_r0_vect) begin
              r0_we    <= 1'b1;
              r0_wdata <= init_r0;
            end
          end
        end
        ST_LOAD: begin
          if (w_lastWrite) begin
            core_run <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A halt still asserted from the previous frame overlaps the
          // launch cycle, so it is only honoured once core_run has dropped.
          if (!core_run && core_halt) begin
            ready   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_frame_loader.sv
// Self-checking bench for core_frame_loader: frame-level vector table, directed
// reset/abort sequences and a randomized run against a cycle-age reference model.
module tb_core_frame_loader;

  localparam int IW = 16;
  localparam int FN = 16;
  localparam int RW = 8;
  localparam int AW = 4;
  localparam int FB = FN * IW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [FB-1:0] insn_data = '0;
  logic          init_r0_vect = 1'b0;
  logic [RW-1:0] init_r0 = '0;
  logic          core_halt = 1'b0;
  logic          ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          r0_we;
  logic [RW-1:0] r0_wdata;
  logic          core_run;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: tracks only "busy since edge mAcc" and derives every
  // output from the frame's age in cycles.
  int            cyc = 0;
  int            mAcc = 0;
  bit            mActive = 1'b0;
  bit            mFirst = 1'b1;
  bit            mPulse = 1'b0;
  bit            mRstLast = 1'b0;
  logic [RW-1:0] mR0Val = '0;
  logic [IW-1:0] mFrame [FN];

  typedef struct {
    logic          gap;
    logic          vect;
    logic          glitch;
    logic [RW-1:0] val;
    int            d;
    logic [IW-1:0] base;
    int            expR0;
    int            expLat;
  } frameVec_t;

  frameVec_t vecs [6];

  core_frame_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .insn_data    (insn_data),
    .init_r0_vect (init_r0_vect),
    .init_r0      (init_r0),
    .core_halt    (core_halt),
    .ready        (ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .r0_we        (r0_we),
    .r0_wdata     (r0_wdata),
    .core_run     (core_run)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] makeFrame(input logic [IW-1:0] base);
    logic [FB-1:0] f;
    for (int k = 0; k < FN; k++) f[k*IW +: IW] = base + IW'(k);
    return f;
  endfunction

  function automatic logic [FB-1:0] randomFrame();
    logic [FB-1:0] f;
    for (int w = 0; w < FB/32; w++) f[w*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic modelUpdate();
    bit accepted;
    accepted = 1'b0;
    cyc++;
    mPulse   = 1'b0;
    mRstLast = 1'b0;
    if (!reset) begin
      mActive  = 1'b0;
      mFirst   = 1'b1;
      mR0Val   = '0;
      mRstLast = 1'b1;
    end else begin
      // Halt counts only when sampled from a cycle after the launch pulse,
      // i.e. the sampled cycle had age FN+1 or more.
      if (mActive && (cyc - mAcc) >= FN + 2 && core_halt) begin
        mActive = 1'b0;
      end else if (!mActive && start) begin
        accepted = 1'b1;
        mActive  = 1'b1;
        mAcc     = cyc;
        for (int k = 0; k < FN; k++) mFrame[k] = insn_data[k*IW +: IW];
        if (mFirst && init_r0_vect) begin
          mPulse = 1'b1;
          mR0Val = init_r0;
        end
      end
      if (accepted) mFirst = 1'b0;
      if (!start) mFirst = 1'b1;
    end
  endtask

  task automatic compareModel();
    int            age;
    logic [AW-1:0] idx;
    age = cyc - mAcc;
    idx = AW'(age);
    checkOutput("ready", 32'(ready), 32'(!mActive));
    checkOutput("imem_we", 32'(imem_we), 32'(mActive && age < FN));
    checkOutput("core_run", 32'(core_run), 32'(mActive && age == FN));
    checkOutput("r0_we", 32'(r0_we), 32'(mPulse));
    checkOutput("r0_wdata", 32'(r0_wdata), 32'(mR0Val));
    if (mActive && age < FN) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(age));
      checkOutput("imem_wdata", 32'(imem_wdata), 32'(mFrame[idx]));
    end else if (mRstLast) begin
      checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    #1;
    compareModel();
  endtask

  // Runs one frame with start held high; halt goes high in cycle FN+1+d
  // counted from the accept edge (and also in cycle FN+1 when glitch is set).
  task automatic runFrame(input logic gap, input logic vect, input logic glitch,
                          input logic [RW-1:0] val, input int d, input logic [IW-1:0] base,
                          output int r0Cnt, output logic [RW-1:0] r0Seen,
                          output int runCnt, output int wrCnt, output int lat);
    int c;
    r0Cnt = 0; r0Seen = '0; runCnt = 0; wrCnt = 0;
    if (gap) begin
      start = 1'b0;
      applyStimulus();
    end
    start = 1'b1; init_r0_vect = vect; init_r0 = val; core_halt = 1'b0;
    insn_data = makeFrame(base);
    applyStimulus();
    insn_data = '1;
    init_r0   = ~val;
    for (c = 1; c < FN + 40; c++) begin
      if (ready) break;
      if (r0_we) begin
        r0Cnt++;
        r0Seen = r0_wdata;
      end
      if (core_run) runCnt++;
      if (imem_we) begin
        checkOutput("frame_addr", 32'(imem_addr), 32'(wrCnt));
        checkOutput("frame_data", 32'(imem_wdata), 32'(base + IW'(wrCnt)));
        wrCnt++;
      end
      core_halt = (c == FN + 1 + d) || (glitch && c == FN + 1);
      applyStimulus();
    end
    core_halt = 1'b0;
    lat = c;
  endtask

  initial begin
    int            r0Cnt, runCnt, wrCnt, lat;
    logic [RW-1:0] r0Seen;
    int            weCnt, runAfter;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h5C, 3, 16'hA000, 1, 21};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 16'hB000, 0, 19};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h22, 5, 16'hC000, 0, 23};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h33, 2, 16'hD000, 0, 20};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h44, 1, 16'hE000, 0, 19};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'hA7, 4, 16'hF000, 1, 22};

    reset = 1'b0; start = 1'b1; init_r0_vect = 1'b1; init_r0 = 8'hFF;
    insn_data = makeFrame(16'h5555);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_we", 32'(imem_we), 32'd0);
      checkOutput("rst_run", 32'(core_run), 32'd0);
      checkOutput("rst_r0_we", 32'(r0_we), 32'd0);
      checkOutput("rst_r0_wdata", 32'(r0_wdata), 32'd0);
    end
    reset = 1'b1; start = 1'b0;
    applyStimulus();

    for (int i = 0; i < 6; i++) begin
      runFrame(vecs[i].gap, vecs[i].vect, vecs[i].glitch, vecs[i].val, vecs[i].d,
               vecs[i].base, r0Cnt, r0Seen, runCnt, wrCnt, lat);
      checkOutput($sformatf("v%0d_r0_pulses", i), 32'(r0Cnt), 32'(vecs[i].expR0));
      if (vecs[i].expR0 != 0)
        checkOutput($sformatf("v%0d_r0_value", i), 32'(r0Seen), 32'(vecs[i].val));
      checkOutput($sformatf("v%0d_run_pulses", i), 32'(runCnt), 32'd1);
      checkOutput($sformatf("v%0d_writes", i), 32'(wrCnt), 32'(FN));
      checkOutput($sformatf("v%0d_ready_cycle", i), 32'(lat), 32'(vecs[i].expLat));
    end

    // Abort mid-load at write 7, then reload cleanly.
    start = 1'b0;
    applyStimulus();
    start = 1'b1; init_r0_vect = 1'b0; insn_data = makeFrame(16'h1200);
    applyStimulus();
    insn_data = '0;
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("abort_at_write7", 32'(imem_addr), 32'd7);
    reset = 1'b0; start = 1'b0;
    applyStimulus();
    reset = 1'b1;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_we", 32'(imem_we), 32'd0);
    weCnt = 0; runAfter = 0;
    for (int i = 0; i < FN + 8; i++) begin
      applyStimulus();
      if (imem_we) weCnt++;
      if (core_run) runAfter++;
    end
    checkOutput("abort_no_writes", 32'(weCnt), 32'd0);
    checkOutput("abort_no_run", 32'(runAfter), 32'd0);
    runFrame(1'b0, 1'b1, 1'b0, 8'h3C, 1, 16'h7700, r0Cnt, r0Seen, runCnt, wrCnt, lat);
    checkOutput("reload_r0_pulses", 32'(r0Cnt), 32'd1);
    checkOutput("reload_r0_value", 32'(r0Seen), 32'h3C);
    checkOutput("reload_writes", 32'(wrCnt), 32'(FN));
    checkOutput("reload_ready_cycle", 32'(lat), 32'd19);

    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) != 0);
      start        = ($urandom_range(0, 9) < 8);
      init_r0_vect = 1'($urandom_range(0, 1));
      init_r0      = RW'($urandom());
      core_halt    = ($urandom_range(0, 3) == 0);
      insn_data    = randomFrame();
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
